// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the fetch-stage branch predictor.
//   btb_entry_t : BTB line layout {valid, tag, target} for the default
//                 geometry (9-bit PC, 16 entries -> 3-bit tag). The top
//                 builds the same layout at its own parameterised widths.
//   BHT_RESET   : counter value loaded on reset (weakly not taken).
//   BP_BIMODAL / BP_GSHARE : values of the MODE parameter.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_DEF_PC_W  = 9;
    localparam int BP_DEF_TAG_W = 3;

    localparam logic [1:0] BHT_RESET = 2'b01;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    typedef struct packed {
        logic                    valid;
        logic [BP_DEF_TAG_W-1:0] tag;
        logic [BP_DEF_PC_W-1:0]  target;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// ---------------------------------------------------------------------------
// bp_sat_ctr
// Two-bit saturating up/down counter step, used for BHT training.
//   cnt_i : current counter value
//   up_i  : 1 = count towards strongly taken, 0 = towards strongly not taken
//   cnt_o : next counter value, clamped at 0 and 3
// ---------------------------------------------------------------------------
module bp_sat_ctr (
    input  logic [1:0] cnt_i,
    input  logic       up_i,
    output logic [1:0] cnt_o
);

    // Step the counter one place in the requested direction, holding at the ends.
    always_comb begin
        cnt_o = cnt_i;
        if (up_i) begin
            if (cnt_i != 2'b11) begin
                cnt_o = cnt_i + 2'd1;
            end
        end else begin
            if (cnt_i != 2'b00) begin
                cnt_o = cnt_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-stage predictor for the 5-stage RV32I pipeline: a tagged direct-mapped
// BTB plus a 2-bit-counter BHT, indexed bimodally or gshare-style. Lookup and
// misprediction detection are combinational; training happens on the clock
// edge in which EX resolves a control transfer.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   if_pc               : fetch PC to predict for
//   pred_taken/_target  : prediction (target is if_pc+4 when not taken)
//   pred_ghr            : history snapshot to carry down the pipe
//   ex_valid            : a branch/jal/jalr resolves in EX this cycle
//   ex_pc, ex_ghr       : its PC and the history captured at its fetch
//   ex_taken/_target    : actual outcome
//   ex_pred_taken/_target : prediction made at its fetch
//   mispredict          : flush IF/ID, ID/EX and fetch from redirect_pc
//   redirect_pc         : correct next PC for the resolving instruction
//   stat_clr            : synchronous clear of both statistics counters
//   br_count, mp_count  : resolved transfers / mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int MODE    = BP_BIMODAL,
    parameter int GHR_W   = $clog2(ENTRIES),
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [GHR_W-1:0] ex_ghr,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_target,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } btb_line_t;

    btb_line_t        btb_q [ENTRIES];
    logic [1:0]       bht_q [ENTRIES];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [CNT_W-1:0] brCount_q;
    logic [CNT_W-1:0] brCount_d;
    logic [CNT_W-1:0] mpCount_q;
    logic [CNT_W-1:0] mpCount_d;

    logic [IDX_W-1:0] fetchPcIdx;
    logic [IDX_W-1:0] fetchBhtIdx;
    logic [TAG_W-1:0] fetchTag;
    btb_line_t        fetchLine;
    logic             fetchHit;

    logic [IDX_W-1:0] exPcIdx;
    logic [IDX_W-1:0] exBhtIdx;
    logic [TAG_W-1:0] exTag;
    logic [1:0]       exCnt;
    logic [1:0]       exCntNext;

    // History only perturbs the BHT index in gshare mode; the BTB index never uses it.
    function automatic logic [IDX_W-1:0] histMix(input logic [GHR_W-1:0] h);
        if (MODE == BP_GSHARE) begin
            return IDX_W'(h);
        end
        return '0;
    endfunction

    // Lookup path
    assign fetchPcIdx  = if_pc[IDX_W+1:2];
    assign fetchTag    = if_pc[PC_W-1:IDX_W+2];
    assign fetchBhtIdx = fetchPcIdx ^ histMix(ghr_q);
    assign fetchLine   = btb_q[fetchPcIdx];
    assign fetchHit    = fetchLine.valid && (fetchLine.tag == fetchTag);

    assign pred_taken  = fetchHit && bht_q[fetchBhtIdx][1];
    assign pred_target = pred_taken ? fetchLine.target : if_pc + PC_W'(4);
    assign pred_ghr    = ghr_q;

    // Resolution path: a taken transfer to the wrong target is also a mispredict.
    assign mispredict  = ex_valid &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = (ex_valid && ex_taken) ? ex_target : ex_pc + PC_W'(4);

    // Training path: the BHT slot is the one the instruction was predicted from,
    // so its index is rebuilt from the history it carried, not the live GHR.
    assign exPcIdx  = ex_pc[IDX_W+1:2];
    assign exTag    = ex_pc[PC_W-1:IDX_W+2];
    assign exBhtIdx = exPcIdx ^ histMix(ex_ghr);
    assign exCnt    = bht_q[exBhtIdx];

    bp_sat_ctr u_satCtr (
        .cnt_i (exCnt),
        .up_i  (ex_taken),
        .cnt_o (exCntNext)
    );

    generate
        if (GHR_W == 1) begin : g_ghrOne
            assign ghr_d = ex_taken;
        end else begin : g_ghrShift
            assign ghr_d = {ghr_q[GHR_W-2:0], ex_taken};
        end
    endgenerate

    assign br_count = brCount_q;
    assign mp_count = mpCount_q;

    // Statistics: clear wins over counting; both counters stick at all-ones.
    always_comb begin
        brCount_d = brCount_q;
        mpCount_d = mpCount_q;
        if (stat_clr) begin
            brCount_d = '0;
            mpCount_d = '0;
        end else if (ex_valid) begin
            if (!(&brCount_q)) begin
                brCount_d = brCount_q + CNT_W'(1);
            end
            if (mispredict && !(&mpCount_q)) begin
                mpCount_d = mpCount_q + CNT_W'(1);
            end
        end
    end

    // Table and history state. Lookups read the pre-edge contents, so a
    // same-cycle lookup of the entry being trained sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
                bht_q[i] <= BHT_RESET;
            end
            ghr_q     <= '0;
            brCount_q <= '0;
            mpCount_q <= '0;
        end else begin
            if (ex_valid) begin
                bht_q[exBhtIdx] <= exCntNext;
                if (ex_taken) begin
                    btb_q[exPcIdx] <= {1'b1, exTag, ex_target};
                end
                ghr_q <= ghr_d;
            end
            brCount_q <= brCount_d;
            mpCount_q <= mpCount_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. Two instances share most stimulus:
// dutB is bimodal with 16-bit counters, dutG is gshare (4-bit history) with
// 3-bit counters so counter saturation is reachable. Expected values are
// pushed into a scoreboard queue as each cycle is driven; a monitor drains
// the queue on the falling edge and compares against the live outputs.
module tb_branch_predictor;
    import bp_pkg::*;

    localparam int SEL_PT_B   = 0;
    localparam int SEL_PTGT_B = 1;
    localparam int SEL_GHR_B  = 2;
    localparam int SEL_BR_B   = 3;
    localparam int SEL_MP_B   = 4;
    localparam int SEL_MISP_B = 5;
    localparam int SEL_RED_B  = 6;
    localparam int SEL_PT_G   = 7;
    localparam int SEL_PTGT_G = 8;
    localparam int SEL_GHR_G  = 9;
    localparam int SEL_MISP_G = 10;
    localparam int SEL_BR_G   = 11;
    localparam int SEL_MP_G   = 12;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] ifPc, exPc, exTarget, exPredTargetB, exPredTargetG;
    logic [3:0] exGhr;
    logic       exValid, exTaken, exPredTakenB, exPredTakenG, statClr;

    logic        predTakenB, mispB;
    logic [8:0]  predTargetB, redirB;
    logic [3:0]  predGhrB;
    logic [15:0] brB, mpB;

    logic        predTakenG, mispG;
    logic [8:0]  predTargetG, redirG;
    logic [3:0]  predGhrG;
    logic [2:0]  brG, mpG;

    always #5 clk = ~clk;

    branch_predictor #(.PC_W(9), .ENTRIES(16), .MODE(BP_BIMODAL), .GHR_W(4), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset), .if_pc(ifPc),
        .pred_taken(predTakenB), .pred_target(predTargetB), .pred_ghr(predGhrB),
        .ex_valid(exValid), .ex_pc(exPc), .ex_ghr(exGhr), .ex_taken(exTaken),
        .ex_target(exTarget), .ex_pred_taken(exPredTakenB), .ex_pred_target(exPredTargetB),
        .mispredict(mispB), .redirect_pc(redirB), .stat_clr(statClr),
        .br_count(brB), .mp_count(mpB)
    );

    branch_predictor #(.PC_W(9), .ENTRIES(16), .MODE(BP_GSHARE), .GHR_W(4), .CNT_W(3)) dutG (
        .clk(clk), .reset(reset), .if_pc(ifPc),
        .pred_taken(predTakenG), .pred_target(predTargetG), .pred_ghr(predGhrG),
        .ex_valid(exValid), .ex_pc(exPc), .ex_ghr(exGhr), .ex_taken(exTaken),
        .ex_target(exTarget), .ex_pred_taken(exPredTakenG), .ex_pred_target(exPredTargetG),
        .mispredict(mispG), .redirect_pc(redirG), .stat_clr(statClr),
        .br_count(brG), .mp_count(mpG)
    );

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic [8:0] ifP, input logic v, input logic [8:0] pc,
                                 input logic tk, input logic [8:0] tgt, input logic pTk,
                                 input logic [8:0] pTgt, input logic clr, input logic [3:0] ghr);
        @(posedge clk);
        #1;
        ifPc          = ifP;
        exValid       = v;
        exPc          = pc;
        exTaken       = tk;
        exTarget      = tgt;
        exPredTakenB  = pTk;
        exPredTargetB = pTgt;
        exPredTakenG  = pTk;
        exPredTargetG = pTgt;
        statClr       = clr;
        exGhr         = ghr;
    endtask

    task automatic idle(input logic [8:0] ifP);
        applyStimulus(ifP, 1'b0, ifP, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 4'h0);
    endtask

    // Queue an expectation for the cycle currently being driven.
    task automatic checkOutput(input string name, input int sel, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    // Monitor: compare every pending expectation against the settled outputs.
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.sel)
                    SEL_PT_B:   act = 16'(predTakenB);
                    SEL_PTGT_B: act = 16'(predTargetB);
                    SEL_GHR_B:  act = 16'(predGhrB);
                    SEL_BR_B:   act = brB;
                    SEL_MP_B:   act = mpB;
                    SEL_MISP_B: act = 16'(mispB);
                    SEL_RED_B:  act = 16'(redirB);
                    SEL_PT_G:   act = 16'(predTakenG);
                    SEL_PTGT_G: act = 16'(predTargetG);
                    SEL_GHR_G:  act = 16'(predGhrG);
                    SEL_MISP_G: act = 16'(mispG);
                    SEL_BR_G:   act = 16'(brG);
                    SEL_MP_G:   act = 16'(mpG);
                    default:    act = 16'hxxxx;
                endcase
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        logic [3:0]  gsGhr [16];
        logic [15:0] gsPredG;
        logic [15:0] gsMispG;
        logic [15:0] gsPredB;
        gsGhr   = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5,
                    4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};
        gsPredG = 16'h5540;
        gsMispG = 16'h0015;
        gsPredB = 16'hAAAA;

        reset = 1'b0;
        ifPc = '0; exPc = '0; exTarget = '0; exPredTargetB = '0; exPredTargetG = '0;
        exGhr = '0; exValid = 1'b0; exTaken = 1'b0; exPredTakenB = 1'b0;
        exPredTakenG = 1'b0; statClr = 1'b0;

        // Held in reset
        applyStimulus(9'h040, 1'b0, 9'h040, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 4'h0);
        checkOutput("rst_pred_taken", SEL_PT_B, 16'h0);
        checkOutput("rst_pred_target", SEL_PTGT_B, 16'h044);
        checkOutput("rst_pred_ghr", SEL_GHR_B, 16'h0);
        checkOutput("rst_br_count", SEL_BR_B, 16'h0);
        checkOutput("rst_mp_count", SEL_MP_B, 16'h0);
        checkOutput("idle_mispredict", SEL_MISP_B, 16'h0);
        checkOutput("idle_redirect", SEL_RED_B, 16'h044);

        // Cold BTB: taken 0x040 -> 0x010 predicted not taken
        applyStimulus(9'h040, 1'b1, 9'h040, 1'b1, 9'h010, 1'b0, 9'h044, 1'b0, 4'h0);
        reset = 1'b1;
        checkOutput("cold_mispredict", SEL_MISP_B, 16'h1);
        checkOutput("cold_redirect", SEL_RED_B, 16'h010);
        checkOutput("same_cycle_old_lookup", SEL_PT_B, 16'h0);
        checkOutput("same_cycle_old_target", SEL_PTGT_B, 16'h044);

        idle(9'h040);
        checkOutput("learned_taken", SEL_PT_B, 16'h1);
        checkOutput("learned_target", SEL_PTGT_B, 16'h010);
        checkOutput("br_after_first", SEL_BR_B, 16'd1);
        checkOutput("mp_after_first", SEL_MP_B, 16'd1);
        checkOutput("ghr_after_first", SEL_GHR_B, 16'h1);

        // Hysteresis: two more correct taken, then two not-taken
        applyStimulus(9'h040, 1'b1, 9'h040, 1'b1, 9'h010, 1'b1, 9'h010, 1'b0, 4'h0);
        checkOutput("correct_no_misp", SEL_MISP_B, 16'h0);
        checkOutput("correct_redirect", SEL_RED_B, 16'h010);
        applyStimulus(9'h040, 1'b1, 9'h040, 1'b1, 9'h010, 1'b1, 9'h010, 1'b0, 4'h0);
        checkOutput("correct_no_misp2", SEL_MISP_B, 16'h0);
        idle(9'h040);
        checkOutput("strong_taken", SEL_PT_B, 16'h1);
        checkOutput("br_after_three", SEL_BR_B, 16'd3);
        checkOutput("mp_after_three", SEL_MP_B, 16'd1);

        applyStimulus(9'h040, 1'b1, 9'h040, 1'b0, 9'h010, 1'b1, 9'h010, 1'b0, 4'h0);
        checkOutput("nt_mispredict", SEL_MISP_B, 16'h1);
        checkOutput("nt_redirect", SEL_RED_B, 16'h044);
        idle(9'h040);
        checkOutput("hyst_still_taken", SEL_PT_B, 16'h1);
        checkOutput("hyst_target", SEL_PTGT_B, 16'h010);
        checkOutput("br_hyst", SEL_BR_B, 16'd4);
        checkOutput("mp_hyst", SEL_MP_B, 16'd2);
        applyStimulus(9'h040, 1'b1, 9'h040, 1'b0, 9'h010, 1'b1, 9'h010, 1'b0, 4'h0);
        checkOutput("nt_mispredict2", SEL_MISP_B, 16'h1);
        idle(9'h040);
        checkOutput("hyst_flipped", SEL_PT_B, 16'h0);
        checkOutput("hyst_flip_target", SEL_PTGT_B, 16'h044);
        checkOutput("br_flip", SEL_BR_B, 16'd5);
        checkOutput("mp_flip", SEL_MP_B, 16'd3);

        // Aliasing: 0x040 and 0x140 share index 0 with tags 1 and 5
        applyStimulus(9'h040, 1'b1, 9'h040, 1'b1, 9'h010, 1'b0, 9'h044, 1'b0, 4'h0);
        checkOutput("retrain_misp", SEL_MISP_B, 16'h1);
        idle(9'h140);
        checkOutput("alias_miss", SEL_PT_B, 16'h0);
        checkOutput("alias_miss_target", SEL_PTGT_B, 16'h144);
        applyStimulus(9'h040, 1'b1, 9'h140, 1'b1, 9'h020, 1'b1, 9'h030, 1'b0, 4'h0);
        checkOutput("wrong_target_misp", SEL_MISP_B, 16'h1);
        checkOutput("wrong_target_redirect", SEL_RED_B, 16'h020);
        checkOutput("alias_pre_update_hit", SEL_PT_B, 16'h1);
        checkOutput("alias_pre_update_tgt", SEL_PTGT_B, 16'h010);
        idle(9'h040);
        checkOutput("alias_evicted", SEL_PT_B, 16'h0);
        checkOutput("alias_evicted_tgt", SEL_PTGT_B, 16'h044);
        checkOutput("br_alias", SEL_BR_B, 16'd7);
        checkOutput("mp_alias", SEL_MP_B, 16'd5);
        idle(9'h140);
        checkOutput("alias_new_hit", SEL_PT_B, 16'h1);
        checkOutput("alias_new_target", SEL_PTGT_B, 16'h020);

        // PC wrap
        idle(9'h1FC);
        checkOutput("wrap_pred_target", SEL_PTGT_B, 16'h000);
        checkOutput("wrap_redirect", SEL_RED_B, 16'h000);

        // stat_clr with a resolution in the same cycle
        applyStimulus(9'h040, 1'b1, 9'h104, 1'b0, 9'h0C0, 1'b0, 9'h108, 1'b1, 4'h0);
        checkOutput("clr_cycle_no_misp", SEL_MISP_B, 16'h0);
        checkOutput("clr_cycle_redirect", SEL_RED_B, 16'h108);
        checkOutput("clr_cycle_br_old", SEL_BR_B, 16'd7);
        applyStimulus(9'h040, 1'b1, 9'h104, 1'b1, 9'h0C0, 1'b0, 9'h108, 1'b0, 4'h0);
        checkOutput("cleared_br", SEL_BR_B, 16'd0);
        checkOutput("cleared_mp", SEL_MP_B, 16'd0);
        checkOutput("post_clr_misp", SEL_MISP_B, 16'h1);
        checkOutput("post_clr_redirect", SEL_RED_B, 16'h0C0);
        checkOutput("ghr_pattern", SEL_GHR_B, 16'h6);
        idle(9'h140);
        checkOutput("pre_reset_hit", SEL_PT_B, 16'h1);
        checkOutput("pre_reset_target", SEL_PTGT_B, 16'h020);
        checkOutput("pre_reset_br", SEL_BR_B, 16'd1);
        checkOutput("pre_reset_mp", SEL_MP_B, 16'd1);
        checkOutput("pre_reset_ghr", SEL_GHR_B, 16'hD);

        // Asynchronous reset in the middle of an update, checked before any rising edge
        applyStimulus(9'h140, 1'b1, 9'h140, 1'b1, 9'h050, 1'b1, 9'h020, 1'b0, 4'h0);
        reset = 1'b0;
        checkOutput("async_rst_pred", SEL_PT_B, 16'h0);
        checkOutput("async_rst_target", SEL_PTGT_B, 16'h144);
        checkOutput("async_rst_br", SEL_BR_B, 16'd0);
        checkOutput("async_rst_mp", SEL_MP_B, 16'd0);
        checkOutput("async_rst_ghr", SEL_GHR_B, 16'h0);
        idle(9'h140);
        reset = 1'b1;
        checkOutput("rst_write_discarded", SEL_PT_B, 16'h0);
        checkOutput("rst_ghr_held", SEL_GHR_B, 16'h0);
        idle(9'h104);
        checkOutput("rst_btb_cleared", SEL_PT_B, 16'h0);
        checkOutput("rst_btb_cleared_tgt", SEL_PTGT_B, 16'h108);

        // Fresh start for the alternating-pattern comparison
        applyStimulus(9'h080, 1'b0, 9'h080, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 4'h0);
        reset = 1'b0;
        idle(9'h080);
        reset = 1'b1;

        for (int k = 0; k < 16; k++) begin
            applyStimulus(9'h080, 1'b1, 9'h080, ~k[0], 9'h0F0, gsPredB[k],
                          gsPredB[k] ? 9'h0F0 : 9'h084, 1'b0, gsGhr[k]);
            exPredTakenG  = gsPredG[k];
            exPredTargetG = gsPredG[k] ? 9'h0F0 : 9'h084;
            checkOutput($sformatf("gs_ghr_%0d", k), SEL_GHR_G, 16'(gsGhr[k]));
            checkOutput($sformatf("gs_pred_%0d", k), SEL_PT_G, 16'(gsPredG[k]));
            checkOutput($sformatf("gs_tgt_%0d", k), SEL_PTGT_G, gsPredG[k] ? 16'h0F0 : 16'h084);
            checkOutput($sformatf("gs_misp_%0d", k), SEL_MISP_G, 16'(gsMispG[k]));
            checkOutput($sformatf("bm_pred_%0d", k), SEL_PT_B, 16'(gsPredB[k]));
            checkOutput($sformatf("bm_misp_%0d", k), SEL_MISP_B, 16'h1);
        end
        idle(9'h080);
        checkOutput("gs_mp_final", SEL_MP_G, 16'd3);
        checkOutput("gs_br_saturated", SEL_BR_G, 16'd7);
        checkOutput("bm_mp_final", SEL_MP_B, 16'd16);
        checkOutput("bm_br_final", SEL_BR_B, 16'd16);

        // Let the monitor drain, bounded
        for (int i = 0; i < 5 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            failures += sbq.size();
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
